// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default line
// parameters, common to the receive buffer and the matching transmitter.
package uart_pkg;

    localparam int UART_N       = 7;    // data MSB index, byte width N+1
    localparam int UART_DVSR    = 163;  // 50 MHz / (16 x 19200)
    localparam int UART_SB_TICK = 16;   // oversampling ticks per stop bit

    // One-hot receiver states.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } rx_state_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Link between the UART receive buffer and the operand/opcode sequencer.
// master: the receive buffer itself; slave: the sequencer that pops bytes.
interface uart_rx_buffer_if
    import uart_pkg::*;
#(
    parameter int N = UART_N
) ();

    logic         rx;
    logic         rd_uart;
    logic [N:0]   r_data;
    logic         full_rx;
    logic         empty_rx;
    logic         frame_err;
    logic         overrun;

    modport master (
        input  rx,
        input  rd_uart,
        output r_data,
        output full_rx,
        output empty_rx,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx,
        output rd_uart,
        input  r_data,
        input  full_rx,
        input  empty_rx,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO for received UART data. A push into a
// full FIFO is dropped (and flagged) unless a pop frees a slot that cycle.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int N = UART_N,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [N:0]   wr_data,
    input  logic         pop,
    output logic [N:0]   rd_data,
    output logic [W:0]   count_next,
    output logic         overrun
);

    localparam int         DEPTH    = 2 ** W;
    localparam logic [W:0] CNT_FULL = (W + 1)'(DEPTH);

    logic [N:0]   mem_r [DEPTH];
    logic [W-1:0] wr_ptr_r;
    logic [W-1:0] rd_ptr_r;
    logic [W:0]   count_r;
    logic         overrun_r;

    logic         pop_ok_s;
    logic         push_ok_s;
    logic [W:0]   count_next_s;

    // Accept/ignore decisions and the resulting occupancy.
    always_comb begin
        pop_ok_s     = pop && (count_r != '0);
        push_ok_s    = push && ((count_r != CNT_FULL) || pop_ok_s);
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + (W + 1)'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - (W + 1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointer, occupancy and overrun bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + W'(1);
            end
            count_r   <= count_next_s;
            overrun_r <= push && !push_ok_s;
        end
    end

    // Storage; entries are only visible through rd_ptr while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data    = (count_r == '0) ? '0 : mem_r[rd_ptr_r];
    assign count_next = count_next_s;
    assign overrun    = overrun_r;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive front end: 16x oversampled 8N1 deserialiser with its own
// baud-tick divider, feeding a small FWFT FIFO read by the sequencer.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int N       = UART_N,
    parameter int DVSR    = UART_DVSR,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int W       = 2,
    parameter int THRESH  = 3
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_buffer_if.master    bus
);

    localparam int            DW          = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [DW-1:0] DIV_LAST    = DW'(DVSR - 1);
    localparam int            NW          = (N > 0) ? $clog2(N + 1) : 1;
    localparam logic [NW-1:0] N_LAST      = NW'(N);
    localparam logic [3:0]    S_START_MID = 4'd7;
    localparam logic [3:0]    S_BIT_LAST  = 4'd15;
    localparam logic [3:0]    S_STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [W:0]    CNT_THRESH  = (W + 1)'(THRESH);

    logic [DW-1:0] div_r;
    logic          tick_s;

    rx_state_t     state_r;
    logic [3:0]    s_r;
    logic [NW-1:0] n_r;
    logic [N:0]    b_r;
    logic          push_r;
    logic          frame_err_r;

    logic [N:0]    fifo_rd_data_s;
    logic [W:0]    fifo_count_next_s;
    logic          fifo_overrun_s;
    logic          empty_r;
    logic          full_r;

    // Free-running oversampling divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (div_r == DIV_LAST) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    assign tick_s = (div_r == DIV_LAST);

    // Receiver: start detect, mid-bit sampling, stop check, push/error strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            s_r         <= '0;
            n_r         <= '0;
            b_r         <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Start edge is taken on any clock, not only on a tick.
                    if (bus.rx == 1'b0) begin
                        state_r <= START;
                        s_r     <= '0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (s_r == S_START_MID) begin
                            if (bus.rx == 1'b0) begin
                                state_r <= DATA;
                                s_r     <= '0;
                                n_r     <= '0;
                            end else begin
                                // Line went back high before mid-start: glitch.
                                state_r <= IDLE;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (s_r == S_BIT_LAST) begin
                            b_r <= {bus.rx, b_r[N:1]};
                            s_r <= '0;
                            if (n_r == N_LAST) begin
                                state_r <= STOP;
                            end else begin
                                n_r <= n_r + NW'(1);
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (s_r == S_STOP_LAST) begin
                            if (bus.rx == 1'b1) begin
                                push_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                            state_r <= IDLE;
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    s_r     <= '0;
                    n_r     <= '0;
                end
            endcase
        end
    end

    rx_fifo #(
        .N (N),
        .W (W)
    ) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_r),
        .wr_data    (b_r),
        .pop        (bus.rd_uart),
        .rd_data    (fifo_rd_data_s),
        .count_next (fifo_count_next_s),
        .overrun    (fifo_overrun_s)
    );

    // Occupancy flags, registered so they move on the same edge as the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            empty_r <= (fifo_count_next_s == '0);
            full_r  <= (fifo_count_next_s >= CNT_THRESH);
        end
    end

    assign bus.r_data    = fifo_rd_data_s;
    assign bus.empty_rx  = empty_r;
    assign bus.full_rx   = full_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = fifo_overrun_s;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed frames, a queue-based model of the
// received byte stream checked every cycle, plus literal spot checks.
module tb_uart_rx_buffer;

    localparam int N        = 7;
    localparam int DVSR     = 2;
    localparam int SB_TICK  = 16;
    localparam int W        = 2;
    localparam int THRESH   = 3;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = 16 * DVSR;

    logic clk = 1'b0;
    logic reset;

    uart_rx_buffer_if #(.N(N)) bus ();

    uart_rx_buffer #(
        .N       (N),
        .DVSR    (DVSR),
        .SB_TICK (SB_TICK),
        .W       (W),
        .THRESH  (THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stop_edge;
        logic [7:0] data;
        bit         stop_ok;
    } frame_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    frame_t     sched[$];
    logic [7:0] mq[$];
    int         push_edge = -1;
    logic [7:0] push_data;
    bit         exp_ferr;
    bit         exp_ovr;
    int         ferr_seen = 0;
    int         ovr_seen  = 0;
    int         last_push_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Model: edges counted from reset release; ticks fall on edges that are
    // multiples of DVSR. Frames are scheduled by the sender, the FIFO is a queue.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
                sched.delete();
                mq.delete();
                push_edge = -1;
                exp_ferr  = 1'b0;
                exp_ovr   = 1'b0;
            end else begin
                bit pop_ok;
                bit push_req;
                bit push_ok;
                cyc++;
                exp_ferr = 1'b0;
                push_req = (push_edge == cyc);
                pop_ok   = bus.rd_uart && (mq.size() > 0);
                push_ok  = push_req && ((mq.size() < DEPTH) || pop_ok);
                if (pop_ok) void'(mq.pop_front());
                if (push_ok) mq.push_back(push_data);
                exp_ovr = push_req && !push_ok;
                if (sched.size() > 0 && sched[0].stop_edge == cyc) begin
                    if (sched[0].stop_ok) begin
                        push_edge = cyc + 1;
                        push_data = sched[0].data;
                    end else begin
                        exp_ferr = 1'b1;
                    end
                    void'(sched.pop_front());
                end
            end
            @(negedge clk);
            begin
                logic [7:0] er;
                er = (mq.size() > 0) ? mq[0] : 8'h00;
                chk("r_data", bus.r_data, er);
                chk("empty_rx", bus.empty_rx, mq.size() == 0);
                chk("full_rx", bus.full_rx, mq.size() >= THRESH);
                chk("frame_err", bus.frame_err, exp_ferr);
                chk("overrun", bus.overrun, exp_ovr);
                if (bus.frame_err) ferr_seen++;
                if (bus.overrun) ovr_seen++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame starting right now; registers when its stop is judged.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        int e0;
        int first;
        int ticks_to_stop;
        frame_t f;
        e0            = cyc + 1;
        first         = (e0 / DVSR + 1) * DVSR;
        ticks_to_stop = 8 + 16 * (N + 1) + SB_TICK;
        f.stop_edge   = first + (ticks_to_stop - 1) * DVSR;
        f.data        = d;
        f.stop_ok     = stop_ok;
        sched.push_back(f);
        last_push_edge = f.stop_edge + 1;
        bus.rx = 1'b0;
        repeat (BIT_CLKS) step();
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BIT_CLKS) step();
        end
        bus.rx = stop_ok;
        repeat (BIT_CLKS) step();
        bus.rx = 1'b1;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        chk(name, bus.r_data, exp);
        bus.rd_uart = 1'b1;
        step();
        bus.rd_uart = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.rx      = 1'b1;
        bus.rd_uart = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        while (cyc < 10) step();

        // Reset values
        chk("rst_r_data", bus.r_data, 8'h00);
        chk("rst_empty", bus.empty_rx, 1'b1);
        chk("rst_full", bus.full_rx, 1'b0);
        chk("rst_ferr", bus.frame_err, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);

        // 1: three frames, exact first-push edge (start seen at 11, tick 12, stop 314)
        fork
            send_frame(8'h35, 1'b1);
            begin
                while (cyc < 314) step();
                chk("t1_pre_push_empty", bus.empty_rx, 1'b1);
                step();
                chk("t1_push_edge", cyc, 315);
                chk("t1_push_empty", bus.empty_rx, 1'b0);
                chk("t1_push_data", bus.r_data, 8'h35);
            end
        join
        send_frame(8'h0A, 1'b1);
        send_frame(8'h20, 1'b1);
        chk("t1_full", bus.full_rx, 1'b1);
        chk("t1_head", bus.r_data, 8'h35);
        bus.rd_uart = 1'b1;
        step();
        chk("t1_pop1", bus.r_data, 8'h0A);
        chk("t1_full_drop", bus.full_rx, 1'b0);
        step();
        chk("t1_pop2", bus.r_data, 8'h20);
        step();
        bus.rd_uart = 1'b0;
        chk("t1_empty", bus.empty_rx, 1'b1);
        chk("t1_zero", bus.r_data, 8'h00);

        // 2: start glitch of 4 ticks
        bus.rx = 1'b0;
        repeat (4 * DVSR) step();
        bus.rx = 1'b1;
        repeat (200) step();
        chk("t2_empty", bus.empty_rx, 1'b1);
        chk("t2_no_ferr", ferr_seen, 0);

        // 3: framing error
        send_frame(8'hA5, 1'b0);
        repeat (100) step();
        chk("t3_ferr_count", ferr_seen, 1);
        chk("t3_empty", bus.empty_rx, 1'b1);

        // 4: overrun on the fifth byte
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (10) step();
        chk("t4_ovr_count", ovr_seen, 1);
        chk("t4_full", bus.full_rx, 1'b1);
        for (int i = 1; i <= 4; i++) pop_expect("t4_drain", 8'(i));
        chk("t4_empty", bus.empty_rx, 1'b1);

        // 5: pop coincides with the push into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                step();
                while (cyc < last_push_edge - 1) step();
                bus.rd_uart = 1'b1;
                step();
                bus.rd_uart = 1'b0;
            end
        join
        repeat (10) step();
        chk("t5_no_ovr", ovr_seen, 1);
        chk("t5_full", bus.full_rx, 1'b1);
        for (int i = 2; i <= 5; i++) pop_expect("t5_drain", 8'(i));
        chk("t5_empty", bus.empty_rx, 1'b1);

        // 6: reset mid-DATA with a byte already buffered
        send_frame(8'h11, 1'b1);
        chk("t6_pre_head", bus.r_data, 8'h11);
        bus.rx = 1'b0;
        repeat (BIT_CLKS) step();
        bus.rx = 1'b0;
        repeat (BIT_CLKS) step();
        bus.rx = 1'b1;
        repeat (BIT_CLKS + BIT_CLKS / 2) step();
        reset = 1'b1;
        step();
        chk("t6_rst_empty", bus.empty_rx, 1'b1);
        chk("t6_rst_data", bus.r_data, 8'h00);
        chk("t6_rst_full", bus.full_rx, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        send_frame(8'h42, 1'b1);
        repeat (10) step();
        chk("t6_data", bus.r_data, 8'h42);
        chk("t6_not_empty", bus.empty_rx, 1'b0);
        chk("t6_ferr_total", ferr_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
